// File: rtl/xrad_fir_pkg.sv
// Shared types, XENOS mode codes and width helpers for the XRAD FIR engine.
package xrad_fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_OUT  = 2'd3
    } fsm_state_e;

    localparam logic [2:0] XM_ACTIVE = 3'b001;
    localparam logic [2:0] XM_FAULT  = 3'b010;
    localparam logic [2:0] XM_SAFE   = 3'b011;
    localparam logic [2:0] XM_BYPASS = 3'b100;

    // Wide enough that TAPS full-scale products can never overflow.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Identity filter: unity gain on tap 0, silence elsewhere.
    function automatic logic [31:0] default_coef(input int tap, input int frac_bits);
        return (tap == 0) ? (32'd1 << frac_bits) : 32'd0;
    endfunction

endpackage

// File: rtl/xrad_fir_mac.sv
// Shared multiply-accumulate with round-half-up and signed saturation to DATA_W.
module xrad_fir_mac
    import xrad_fir_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 8,
    parameter int FRAC_BITS = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     acc_en_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [DATA_W-1:0] result_o,
    output logic                     sat_flag_o
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam logic signed [ACC_W-1:0] RND_V = ACC_W'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MIN_V = -(ACC_W'(1) <<< (DATA_W - 1));

    logic signed [DATA_W+COEF_W-1:0] prod;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic signed [ACC_W-1:0]         rounded, shifted;

    assign prod = sample_i * coef_i;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        rounded    = acc_q + RND_V;
        shifted    = rounded >>> FRAC_BITS;
        sat_flag_o = 1'b0;
        result_o   = DATA_W'(shifted);
        if (shifted > MAX_V) begin
            result_o   = DATA_W'(MAX_V);
            sat_flag_o = 1'b1;
        end else if (shifted < MIN_V) begin
            result_o   = DATA_W'(MIN_V);
            sat_flag_o = 1'b1;
        end
    end

endmodule

// File: rtl/xrad_fir_engine.sv
// Multi-channel time-multiplexed FIR: per-channel delay lines, one shared MAC,
// round-robin service and a XENOS-controlled output mode.
module xrad_fir_engine
    import xrad_fir_pkg::*;
#(
    parameter  int NUM_CH    = 8,
    parameter  int DATA_W    = 32,
    parameter  int COEF_W    = 16,
    parameter  int TAPS      = 8,
    parameter  int FRAC_BITS = 14,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW        = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid_i,
    input  logic [NUM_CH*DATA_W-1:0] in_data_i,
    output logic [NUM_CH-1:0]        in_ready_o,
    input  logic                     coef_we_i,
    input  logic [AW-1:0]            coef_addr_i,
    input  logic [COEF_W-1:0]        coef_wdata_i,
    output logic                     coef_err_o,
    input  logic [2:0]               xenos_state_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [CH_W-1:0]          out_ch_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic                     busy_o,
    output logic [15:0]              sat_cnt_o,
    output fsm_state_e               state_o
);

    fsm_state_e              state_q;
    logic [NUM_CH-1:0]       pending_q, pending_d, accept, load_mask;
    logic [DATA_W-1:0]       hold_q  [NUM_CH];
    logic [DATA_W-1:0]       delay_q [NUM_CH][TAPS];
    logic [COEF_W-1:0]       coef_q  [TAPS];
    logic [CH_W-1:0]         grant_q, last_q, grant_d;
    logic                    grant_hit;
    logic [AW-1:0]           tap_q;
    logic [2:0]              mode_q;
    logic                    filt_mode;
    logic                    out_valid_q, coef_err_q;
    logic [CH_W-1:0]         out_ch_q;
    logic [DATA_W-1:0]       out_data_q;
    logic [15:0]             sat_cnt_q;
    logic signed [DATA_W-1:0] mac_result;
    logic                    mac_sat;

    assign accept = in_valid_i & ~pending_q;

    // Round-robin search starts one past the last grant and wraps.
    always_comb begin
        grant_hit = 1'b0;
        grant_d   = last_q;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!grant_hit && pending_q[(int'(last_q) + i) % NUM_CH]) begin
                grant_hit = 1'b1;
                grant_d   = CH_W'((int'(last_q) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        load_mask = '0;
        if (state_q == ST_LOAD) begin
            load_mask[grant_q] = 1'b1;
        end
        pending_d = (pending_q & ~load_mask) | accept;
    end

    // Unrecognised mode codes fall back to the filtered result.
    assign filt_mode = (mode_q == XM_ACTIVE) ||
                       !(mode_q inside {XM_FAULT, XM_SAFE, XM_BYPASS});

    xrad_fir_mac #(
        .DATA_W   (DATA_W),
        .COEF_W   (COEF_W),
        .TAPS     (TAPS),
        .FRAC_BITS(FRAC_BITS)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == ST_LOAD),
        .acc_en_i  (state_q == ST_MAC),
        .sample_i  (delay_q[grant_q][tap_q]),
        .coef_i    (coef_q[tap_q]),
        .result_o  (mac_result),
        .sat_flag_o(mac_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            grant_q     <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
            tap_q       <= '0;
            mode_q      <= XM_ACTIVE;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            coef_err_q  <= 1'b0;
            sat_cnt_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                hold_q[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    delay_q[c][t] <= '0;
                end
            end
            for (int t = 0; t < TAPS; t++) begin
                coef_q[t] <= COEF_W'(default_coef(t, FRAC_BITS));
            end
        end else begin
            pending_q  <= pending_d;
            coef_err_q <= 1'b0;
            if (coef_we_i) begin
                if (state_q != ST_IDLE || int'(coef_addr_i) >= TAPS) begin
                    coef_err_q <= 1'b1;
                end else begin
                    coef_q[coef_addr_i] <= coef_wdata_i;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept[c]) begin
                    hold_q[c] <= in_data_i[c*DATA_W +: DATA_W];
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant_hit) begin
                        grant_q <= grant_d;
                        last_q  <= grant_d;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    for (int t = TAPS - 1; t > 0; t--) begin
                        delay_q[grant_q][t] <= delay_q[grant_q][t-1];
                    end
                    delay_q[grant_q][0] <= hold_q[grant_q];
                    tap_q   <= '0;
                    state_q <= ST_MAC;
                end
                ST_MAC: begin
                    tap_q <= tap_q + AW'(1);
                    if (tap_q == AW'(TAPS - 1)) begin
                        mode_q  <= xenos_state_i;
                        state_q <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    // First OUT cycle latches the result; later cycles wait for the sink.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_ch_q    <= grant_q;
                        if (filt_mode) begin
                            out_data_q <= mac_result;
                            if (mac_sat && sat_cnt_q != 16'hFFFF) begin
                                sat_cnt_q <= sat_cnt_q + 16'd1;
                            end
                        end else if (mode_q == XM_FAULT) begin
                            out_data_q <= '1;
                        end else if (mode_q == XM_SAFE) begin
                            out_data_q <= '0;
                            for (int t = 0; t < TAPS; t++) begin
                                delay_q[grant_q][t] <= '0;
                            end
                        end else begin
                            out_data_q <= delay_q[grant_q][0];
                        end
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready_o  = ~pending_q;
    assign coef_err_o  = coef_err_q;
    assign out_valid_o = out_valid_q;
    assign out_ch_o    = out_ch_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign sat_cnt_o   = sat_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_xrad_fir_engine.sv
// Directed bench for xrad_fir_engine: latency, coefficients, saturation,
// round-robin with backpressure, XENOS modes and asynchronous reset.
module tb_xrad_fir_engine;
    import xrad_fir_pkg::*;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 32;
    localparam int COEF_W = 16;
    localparam int TAPS   = 8;
    localparam int W      = 3 + DATA_W;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_CH-1:0]        in_valid = '0;
    logic [NUM_CH*DATA_W-1:0] in_data = '0;
    logic [NUM_CH-1:0]        in_ready;
    logic                     coef_we = 1'b0;
    logic [2:0]               coef_addr = '0;
    logic [COEF_W-1:0]        coef_wdata = '0;
    logic                     coef_err;
    logic [2:0]               xenos = 3'b001;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [2:0]               out_ch;
    logic [DATA_W-1:0]        out_data;
    logic                     busy;
    logic [15:0]              sat_cnt;
    fsm_state_e               state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    xrad_fir_engine #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .FRAC_BITS(14)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .coef_we_i    (coef_we),
        .coef_addr_i  (coef_addr),
        .coef_wdata_i (coef_wdata),
        .coef_err_o   (coef_err),
        .xenos_state_i(xenos),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_ch_o     (out_ch),
        .out_data_o   (out_data),
        .busy_o       (busy),
        .sat_cnt_o    (sat_cnt),
        .state_o      (state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        coef_we   = 1'b0;
        out_ready = 1'b1;
        xenos     = 3'b001;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic push(input int ch, input logic [31:0] d);
        int n;
        n = 0;
        while (!in_ready[ch] && n < 100) begin
            step(1);
            n++;
        end
        if (!in_ready[ch]) check_eq("push_ready", 32'(in_ready[ch]), 1);
        in_valid[ch] = 1'b1;
        in_data[ch*DATA_W +: DATA_W] = d;
        step(1);
        in_valid[ch] = 1'b0;
    endtask

    task automatic coef_write(input int addr, input logic [15:0] d);
        coef_we    = 1'b1;
        coef_addr  = 3'(addr);
        coef_wdata = d;
        step(1);
        coef_we = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            step(1);
            n++;
        end
        if (!out_valid) check_eq("out_valid_wait", 32'(out_valid), 1);
    endtask

    task automatic take(input string tag, input int ch, input logic [31:0] d);
        int n;
        wait_valid(n);
        check_eq({tag, "_ch"}, 32'(out_ch), 32'(ch));
        check_eq({tag, "_data"}, out_data, d);
        out_ready = 1'b1;
        step(1);
    endtask

    initial begin
        int n;
        logic [W-1:0] e;

        do_reset();
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_out_ch", 32'(out_ch), 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_coef_err", 32'(coef_err), 0);
        check_eq("rst_sat_cnt", 32'(sat_cnt), 0);
        check_eq("rst_in_ready", 32'(in_ready), 32'hFF);

        // Identity after reset, result at acceptance edge + TAPS + 3.
        push(0, 32'd1000);
        wait_valid(n);
        check_eq("latency", n, 11);
        check_eq("ident_ch", 32'(out_ch), 0);
        check_eq("ident_data", out_data, 32'd1000);
        step(1);

        // All taps 0.25: k samples of 400 give k*100; a busy write is refused.
        for (int t = 0; t < TAPS; t++) coef_write(t, 16'h1000);
        check_eq("coef_ok_err", 32'(coef_err), 0);
        for (int k = 1; k <= 8; k++) begin
            push(2, 32'd400);
            if (k == 2) begin
                step(3);
                check_eq("busy_mac", 32'(busy), 1);
                coef_write(0, 16'h7FFF);
                check_eq("coef_err_pulse", 32'(coef_err), 1);
                step(1);
                check_eq("coef_err_clear", 32'(coef_err), 0);
            end
            take("avg", 2, 32'(k * 100));
        end

        // Saturation both ways with tap0 near 2.0.
        coef_write(0, 16'h7FFF);
        for (int t = 1; t < TAPS; t++) coef_write(t, 16'h0000);
        push(5, 32'h7FFF_FFFF);
        take("sat_pos", 5, 32'h7FFF_FFFF);
        check_eq("sat_cnt1", 32'(sat_cnt), 1);
        push(5, 32'h8000_0000);
        take("sat_neg", 5, 32'h8000_0000);
        check_eq("sat_cnt2", 32'(sat_cnt), 2);

        // All channels at once with the sink stalled; one result held for 5 cycles.
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_data[c*DATA_W +: DATA_W] = 32'(c * 16 + 3);
            exp_q.push_back({3'(c), 32'(c * 16 + 3)});
        end
        in_valid = '1;
        step(1);
        in_valid = '0;
        for (int i = 0; i < 9; i++) begin
            wait_valid(n);
            e = exp_q.pop_front();
            check_eq("rr_ch", 32'(out_ch), 32'(e[W-1:DATA_W]));
            check_eq("rr_data", out_data, e[DATA_W-1:0]);
            if (i == 3) begin
                push(0, 32'd77);
                exp_q.push_back({3'd0, 32'd77});
                for (int j = 0; j < 4; j++) begin
                    step(1);
                    check_eq("bp_valid", 32'(out_valid), 1);
                    check_eq("bp_ch", 32'(out_ch), 32'(e[W-1:DATA_W]));
                    check_eq("bp_data", out_data, e[DATA_W-1:0]);
                end
            end
            out_ready = 1'b1;
            step(1);
            out_ready = 1'b0;
        end
        out_ready = 1'b1;

        // Modes on ch1 with all taps 1.0 so any leftover history would show.
        for (int t = 0; t < TAPS; t++) coef_write(t, 16'h4000);
        xenos = 3'b010;
        push(1, 32'd123);
        take("fault", 1, 32'hFFFF_FFFF);
        xenos = 3'b100;
        push(1, 32'hFFFF_FFF9);
        take("bypass", 1, 32'hFFFF_FFF9);
        xenos = 3'b011;
        push(1, 32'd50);
        take("safe", 1, 32'd0);
        xenos = 3'b000;
        push(1, 32'd20);
        take("after_safe", 1, 32'd20);
        xenos = 3'b001;
        push(1, 32'd30);
        take("history", 1, 32'd50);

        // Asynchronous reset in the middle of a MAC pass.
        push(3, 32'd999);
        push(6, 32'd5);
        step(3);
        check_eq("pre_rst_state", 32'(state), 32'(ST_MAC));
        check_eq("pre_rst_ready", 32'(in_ready), 32'hBF);
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 0);
        check_eq("arst_out_ch", 32'(out_ch), 0);
        check_eq("arst_out_data", out_data, 0);
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_in_ready", 32'(in_ready), 32'hFF);
        check_eq("arst_sat_cnt", 32'(sat_cnt), 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        push(3, 32'd1000);
        take("post_rst_a", 3, 32'd1000);
        push(3, 32'd500);
        take("post_rst_b", 3, 32'd500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
